// File: rtl/lif_step_sched_if.sv
// Bundle of the step-request handshake, current-fetch bus and spike result
// exchanged between a LIF step controller and its environment.
interface lif_step_sched_if #(
  parameter int ACC_BITS    = 8,
  parameter int IDX_BITS    = 2,
  parameter int NUM_NEURONS = 4
);
  logic                       start;
  logic                       clear;
  logic signed [ACC_BITS-1:0] beta;
  logic signed [ACC_BITS-1:0] threshold;
  logic [IDX_BITS-1:0]        cur_idx;
  logic signed [ACC_BITS-1:0] cur_data;
  logic                       busy;
  logic                       done;
  logic [NUM_NEURONS-1:0]     spike_out;

  // Environment side: requests steps, serves currents, consumes spikes.
  modport master (
    output start, clear, beta, threshold, cur_data,
    input  cur_idx, busy, done, spike_out
  );

  // Controller side.
  modport slave (
    input  start, clear, beta, threshold, cur_data,
    output cur_idx, busy, done, spike_out
  );
endinterface

// File: rtl/lif_step_sched.sv
// Time-multiplexed Leaky-Integrate-and-Fire step controller. One shared
// multiply, add and subtract path walks every neuron in turn per start pulse:
// V = V*beta + I, then fire when V >= threshold and reset by subtraction.
module lif_step_sched #(
  parameter int ACC_BITS    = 8,
  parameter int FRAC_BITS   = 6,
  parameter int NUM_NEURONS = 4,
  parameter int IDX_BITS    = 2
) (
  input  logic             clk,
  input  logic             rst,
  lif_step_sched_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DECAY = 3'd2,
    S_INTEG = 3'd3,
    S_FIRE  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_NEURONS - 1);

  // Fixed-point multiply: floor (arithmetic shift) of the full product, upper
  // overflow bits dropped.
  function automatic logic signed [ACC_BITS-1:0] mult_f(
    input logic signed [ACC_BITS-1:0] a,
    input logic signed [ACC_BITS-1:0] b
  );
    logic signed [2*ACC_BITS-1:0] prod;
    prod = a * b;
    return prod[FRAC_BITS+ACC_BITS-1:FRAC_BITS];
  endfunction

  // Two's-complement wrapping add.
  function automatic logic signed [ACC_BITS-1:0] adder_f(
    input logic signed [ACC_BITS-1:0] a,
    input logic signed [ACC_BITS-1:0] b
  );
    return a + b;
  endfunction

  // Two's-complement wrapping subtract.
  function automatic logic signed [ACC_BITS-1:0] subt_f(
    input logic signed [ACC_BITS-1:0] a,
    input logic signed [ACC_BITS-1:0] b
  );
    return a - b;
  endfunction

  state_t                     state_q, state_d;
  logic [IDX_BITS-1:0]        idx_q, idx_d;
  logic [IDX_BITS-1:0]        cur_idx_q, cur_idx_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic [NUM_NEURONS-1:0]     spike_q, spike_d;
  logic [NUM_NEURONS-1:0]     acc_q, acc_d;
  logic signed [ACC_BITS-1:0] beta_q, beta_d;
  logic signed [ACC_BITS-1:0] thr_q, thr_d;
  logic signed [ACC_BITS-1:0] i_q, i_d;
  logic signed [ACC_BITS-1:0] tmp_q, tmp_d;
  logic signed [ACC_BITS-1:0] v_q [NUM_NEURONS];
  logic signed [ACC_BITS-1:0] v_d [NUM_NEURONS];

  // Next-state logic: sequencer plus the single shared datapath.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cur_idx_d = cur_idx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    spike_d   = spike_q;
    acc_d     = acc_q;
    beta_d    = beta_q;
    thr_d     = thr_q;
    i_d       = i_q;
    tmp_d     = tmp_q;
    v_d       = v_q;
    case (state_q)
      S_IDLE: begin
        if (bus.clear) begin
          for (int n = 0; n < NUM_NEURONS; n++) begin
            v_d[n] = '0;
          end
        end else if (bus.start) begin
          beta_d    = bus.beta;
          thr_d     = bus.threshold;
          idx_d     = '0;
          cur_idx_d = '0;
          acc_d     = '0;
          busy_d    = 1'b1;
          state_d   = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        i_d     = bus.cur_data;
        state_d = S_DECAY;
      end
      S_DECAY: begin
        tmp_d   = mult_f(v_q[idx_q], beta_q);
        state_d = S_INTEG;
      end
      S_INTEG: begin
        tmp_d   = adder_f(tmp_q, i_q);
        state_d = S_FIRE;
      end
      S_FIRE: begin
        if (tmp_q >= thr_q) begin
          v_d[idx_q]   = subt_f(tmp_q, thr_q);
          acc_d[idx_q] = 1'b1;
        end else begin
          v_d[idx_q] = tmp_q;
        end
        if (idx_q == LAST_IDX) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d     = idx_q + IDX_BITS'(1);
          cur_idx_d = idx_q + IDX_BITS'(1);
          state_d   = S_FETCH;
        end
      end
      S_DONE: begin
        spike_d = acc_q;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; async reset abandons any step in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cur_idx_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      spike_q   <= '0;
      acc_q     <= '0;
      beta_q    <= '0;
      thr_q     <= '0;
      i_q       <= '0;
      tmp_q     <= '0;
      for (int n = 0; n < NUM_NEURONS; n++) begin
        v_q[n] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cur_idx_q <= cur_idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      spike_q   <= spike_d;
      acc_q     <= acc_d;
      beta_q    <= beta_d;
      thr_q     <= thr_d;
      i_q       <= i_d;
      tmp_q     <= tmp_d;
      v_q       <= v_d;
    end
  end

  assign bus.cur_idx   = cur_idx_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.spike_out = spike_q;

endmodule

// File: tb/tb_lif_step_sched.sv
// Scoreboard bench for lif_step_sched: a behavioural neuron model predicts the
// spike vector of each step at start time; it is compared when done fires.
module tb_lif_step_sched;

  localparam int ACC = 8;
  localparam int FRAC = 6;
  localparam int NN = 4;
  localparam int IB = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [NN-1:0]         sb_q [$];
  logic signed [ACC-1:0] cur_tab [NN];
  logic signed [ACC-1:0] m_v [NN];

  lif_step_sched_if #(.ACC_BITS(ACC), .IDX_BITS(IB), .NUM_NEURONS(NN)) bus ();

  lif_step_sched #(
    .ACC_BITS(ACC), .FRAC_BITS(FRAC), .NUM_NEURONS(NN), .IDX_BITS(IB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Current source: serves the requested index combinationally.
  always_comb bus.cur_data = cur_tab[bus.cur_idx];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic signed [ACC-1:0] wrap8(input int x);
    logic [31:0] u;
    u = x;
    return u[ACC-1:0];
  endfunction

  // Behavioural model of one step over all neurons; returns the spike vector.
  function automatic logic [NN-1:0] model_step(input logic signed [ACC-1:0] bt,
                                               input logic signed [ACC-1:0] th);
    logic [NN-1:0] s;
    int p;
    logic signed [ACC-1:0] t;
    s = '0;
    for (int n = 0; n < NN; n++) begin
      p = int'(m_v[n]) * int'(bt);
      p = p >>> FRAC;
      t = wrap8(int'(wrap8(p)) + int'(cur_tab[n]));
      if (t >= th) begin
        m_v[n] = wrap8(int'(t) - int'(th));
        s[n] = 1'b1;
      end else begin
        m_v[n] = t;
      end
    end
    return s;
  endfunction

  task automatic set_cur(input int a, input int b, input int c, input int d);
    cur_tab[0] = wrap8(a);
    cur_tab[1] = wrap8(b);
    cur_tab[2] = wrap8(c);
    cur_tab[3] = wrap8(d);
  endtask

  // One step; inject 1 = start pulse during busy, 2 = clear pulse during busy.
  task automatic run_step(input logic signed [ACC-1:0] bt, input logic signed [ACC-1:0] th,
                          input int inject);
    bit seen;
    int dcyc;
    logic [NN-1:0] exp_spk;
    @(negedge clk);
    bus.beta = bt;
    bus.threshold = th;
    bus.start = 1'b1;
    exp_spk = model_step(bt, th);
    sb_q.push_back(exp_spk);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.beta = ~bt;
    bus.threshold = ~th;
    seen = 1'b0;
    dcyc = 0;
    for (int c = 1; c <= 40; c++) begin
      if (!seen) begin
        @(negedge clk);
        check_val("busy_in_step", {31'd0, bus.busy}, 32'd1);
        if (c == 1 || c == 5 || c == 9 || c == 13)
          check_val("cur_idx_fetch", {30'd0, bus.cur_idx}, (c - 1) / 4);
        if (c == 4 || c == 16)
          check_val("cur_idx_hold", {30'd0, bus.cur_idx}, c / 4 - 1);
        if (bus.done) begin
          seen = 1'b1;
          dcyc = c;
        end
        bus.start = (inject == 1) && (c == 3);
        bus.clear = (inject == 2) && (c == 6);
      end
    end
    bus.start = 1'b0;
    bus.clear = 1'b0;
    check_val("done_seen", {31'd0, seen}, 32'd1);
    check_val("done_cycle", dcyc, 32'd17);
    @(negedge clk);
    check_val("done_pulse", {31'd0, bus.done}, 32'd0);
    check_val("busy_after", {31'd0, bus.busy}, 32'd0);
    if (sb_q.size() > 0) begin
      check_val("spike_out", {28'd0, bus.spike_out}, {28'd0, sb_q.pop_front()});
    end else begin
      check_val("sb_underflow", 32'd1, 32'd0);
    end
    @(negedge clk);
    check_val("idle_busy", {31'd0, bus.busy}, 32'd0);
    check_val("idle_done", {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dcnt;
    bus.start = 1'b0;
    bus.clear = 1'b0;
    bus.beta = '0;
    bus.threshold = '0;
    set_cur(0, 0, 0, 0);
    for (int n = 0; n < NN; n++) m_v[n] = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_val("rst_done", {31'd0, bus.done}, 32'd0);
    check_val("rst_spike", {28'd0, bus.spike_out}, 32'd0);
    check_val("rst_cur_idx", {30'd0, bus.cur_idx}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Integration to spike; first step also pulses start while busy.
    set_cur(32, 32, 32, 32);
    run_step(8'sd48, 8'sd64, 1);
    check_val("itg1", {28'd0, bus.spike_out}, 32'h0);
    run_step(8'sd48, 8'sd64, 0);
    check_val("itg2", {28'd0, bus.spike_out}, 32'h0);
    run_step(8'sd48, 8'sd64, 0);
    check_val("itg3", {28'd0, bus.spike_out}, 32'hF);

    // Clear with start in IDLE: clear wins, no step begins.
    @(negedge clk);
    bus.clear = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.clear = 1'b0;
    bus.start = 1'b0;
    for (int n = 0; n < NN; n++) m_v[n] = '0;
    repeat (3) begin
      @(negedge clk);
      check_val("clr_no_busy", {31'd0, bus.busy}, 32'd0);
    end
    set_cur(0, 0, 0, 0);
    run_step(8'sd64, 8'sd1, 2);
    check_val("clr_zero", {28'd0, bus.spike_out}, 32'h0);

    // Wrap and floor behaviour.
    set_cur(100, 100, 100, 100);
    run_step(8'sd64, 8'sd127, 0);
    run_step(8'sd64, 8'sd127, 0);
    check_val("wrap_nospk", {28'd0, bus.spike_out}, 32'h0);
    set_cur(0, 0, 0, 0);
    run_step(8'sd1, 8'sd127, 0);
    run_step(8'sd64, 8'sd0, 0);
    check_val("floor_neg", {28'd0, bus.spike_out}, 32'h0);

    // Per-neuron independence.
    set_cur(64, 0, -32, 63);
    run_step(8'sd0, 8'sd64, 0);
    check_val("indep", {28'd0, bus.spike_out}, 32'h1);
    set_cur(0, 0, 0, 1);
    run_step(8'sd64, 8'sd64, 0);
    check_val("indep_v", {28'd0, bus.spike_out}, 32'h8);

    // Async reset in the middle of a step.
    set_cur(32, 32, 32, 32);
    @(negedge clk);
    bus.beta = 8'sd64;
    bus.threshold = 8'sd1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_val("arst_busy", {31'd0, bus.busy}, 32'd0);
    check_val("arst_done", {31'd0, bus.done}, 32'd0);
    check_val("arst_spike", {28'd0, bus.spike_out}, 32'd0);
    check_val("arst_cur_idx", {30'd0, bus.cur_idx}, 32'd0);
    for (int n = 0; n < NN; n++) m_v[n] = '0;
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.done) dcnt++;
    end
    check_val("arst_no_done", dcnt, 32'd0);
    run_step(8'sd64, 8'sd60, 0);
    check_val("arst_clean", {28'd0, bus.spike_out}, 32'h0);

    check_val("sb_empty", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
